// File: rtl/multicore_out_collector_if.sv
// multicore_out_collector_if: per-core sample inputs and ordered output stream of the collector; COLLECTOR_TAG_EN adds out_core_id
interface multicore_out_collector_if #(
    parameter int NCORES = 48,
    parameter int DW = 32,
    parameter int IDW = 6
);
    logic [NCORES*DW-1:0] io_out_bus;
    logic [NCORES*2-1:0] out_en_bus;
    logic [DW-1:0] out_data;
    logic out_valid;
    logic out_ready;
    logic [NCORES-1:0] core_busy;
    logic overflow;
    logic [15:0] drop_count;
`ifdef COLLECTOR_TAG_EN
    logic [IDW-1:0] out_core_id;
`endif
    modport master (
        input io_out_bus, out_en_bus, out_ready,
`ifdef COLLECTOR_TAG_EN
        output out_core_id,
`endif
        output out_data, out_valid, core_busy, overflow, drop_count
    );
    modport slave (
        output io_out_bus, out_en_bus, out_ready,
`ifdef COLLECTOR_TAG_EN
        input out_core_id,
`endif
        input out_data, out_valid, core_busy, overflow, drop_count
    );
endinterface

// File: rtl/multicore_out_collector.sv
// multicore_out_collector: per-core holding registers, round-robin arbiter and output FIFO with drop accounting; COLLECTOR_TAG_EN adds out_core_id
module multicore_out_collector #(
    parameter int NCORES = 48,
    parameter int DW = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int IDW = 6
) (
    input logic clk,
    input logic rst,
    multicore_out_collector_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DCW = $clog2(NCORES + 1);
`ifdef COLLECTOR_TAG_EN
    localparam int FW = DW + IDW;
`else
    localparam int FW = DW;
`endif
    logic [NCORES-1:0] hold_valid, cap, gmask;
    logic [DW-1:0] hold_data [NCORES];
    logic [IDW-1:0] ptr, gidx;
    logic [DW-1:0] gdata;
    logic found, grant, pop, can_accept, valid;
    logic [DCW-1:0] drops;
    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [FW-1:0] push_entry, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [16:0] drop_sum;
    logic [15:0] drop_q;
    logic overflow_q;
    // round-robin search for the first occupied holding register starting at ptr
    always_comb begin
        found = 1'b0;
        gidx = '0;
        gdata = '0;
        for (int i = 0; i < NCORES; i++) begin
            int j;
            j = int'(ptr) + i;
            j = j >= NCORES ? j - NCORES : j;
            if (!found && hold_valid[j]) begin
                found = 1'b1;
                gidx = IDW'(j);
                gdata = hold_data[j];
            end
        end
    end
    assign valid = count != '0;
    assign pop = valid && bus.out_ready;
    assign can_accept = count < CW'(FIFO_DEPTH) || pop;
    assign grant = found && can_accept;
    assign gmask = grant ? NCORES'(1) << gidx : '0;
    // a strobe lands if its register is free or being granted this cycle, otherwise it is dropped
    always_comb begin
        cap = '0;
        drops = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (bus.out_en_bus[k*2 +: 2] == 2'b01) begin
                cap[k] = !hold_valid[k] || gmask[k];
                drops = drops + DCW'(!cap[k]);
            end
        end
    end
    // occupancy: set on capture, cleared on grant unless recaptured
    always_ff @(posedge clk) begin
        if (rst) hold_valid <= '0;
        else hold_valid <= cap | (hold_valid & ~gmask);
    end
    // sample storage needs no reset since occupancy qualifies it
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCORES; k++)
            if (cap[k]) hold_data[k] <= bus.io_out_bus[k*DW +: DW];
    end
    // pointer moves just past the granted core, wrapping at NCORES
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (grant) ptr <= gidx == IDW'(NCORES - 1) ? '0 : gidx + 1'b1;
    end
`ifdef COLLECTOR_TAG_EN
    assign push_entry = {gidx, gdata};
    assign bus.out_core_id = valid ? head[FW-1:DW] : '0;
`else
    assign push_entry = gdata;
`endif
    // FIFO storage written by each grant
    always_ff @(posedge clk) begin
        if (grant) mem[wr_ptr] <= push_entry;
    end
    // FIFO pointers and occupancy; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(grant);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + CW'(grant) - CW'(pop);
        end
    end
    assign drop_sum = {1'b0, drop_q} + 17'(drops);
    // sticky overflow and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q <= '0;
        end else begin
            overflow_q <= overflow_q || drops != '0;
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
    assign head = mem[rd_ptr];
    assign bus.out_valid = valid;
    assign bus.out_data = valid ? head[DW-1:0] : '0;
    assign bus.core_busy = hold_valid;
    assign bus.overflow = overflow_q;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_multicore_out_collector.sv
// tb_multicore_out_collector: directed tests of the multicore output collector
module tb_multicore_out_collector;
    localparam int NCORES = 48;
    localparam int DW = 32;
    localparam int FIFO_DEPTH = 16;
    localparam int IDW = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    multicore_out_collector_if #(.NCORES(NCORES), .DW(DW), .IDW(IDW)) bus();

    multicore_out_collector #(.NCORES(NCORES), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic [1:0] en, input logic [DW-1:0] val);
        bus.out_en_bus[k*2 +: 2] = en;
        bus.io_out_bus[k*DW +: DW] = val;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.out_en_bus = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        bus.io_out_bus = '0;
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got %0h want 0", bus.out_data); end
        checks++;
        if (bus.core_busy !== '0) begin failures++; $display("FAIL reset_busy got %0h want 0", bus.core_busy); end
        checks++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got %b/%0d want 0/0", bus.overflow, bus.drop_count); end
`ifdef COLLECTOR_TAG_EN
        checks++;
        if (bus.out_core_id !== '0) begin failures++; $display("FAIL reset_id got %0d want 0", bus.out_core_id); end
`endif
    endtask

    task automatic test_single_strobe();
        logic [NCORES-1:0] exp_busy;
        exp_busy = NCORES'(1) << 5;
        bus.out_ready = 1'b1;
        set_core(5, 2'b01, DW'(-1234));
        tick();
        bus.out_en_bus = '0;
        checks++;
        if (bus.core_busy !== exp_busy || bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_n1 got busy=%0h valid=%b want %0h/0", bus.core_busy, bus.out_valid, exp_busy); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FB2E) begin failures++; $display("FAIL single_n2 got valid=%b data=%0h want 1/fffffb2e", bus.out_valid, bus.out_data); end
        checks++;
        if (bus.core_busy !== '0) begin failures++; $display("FAIL single_busy_clear got %0h want 0", bus.core_busy); end
`ifdef COLLECTOR_TAG_EN
        checks++;
        if (bus.out_core_id !== IDW'(5)) begin failures++; $display("FAIL single_id got %0d want 5", bus.out_core_id); end
`endif
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_all_cores();
        int got[$];
        int ids[$];
        int first;
        int last;
        first = -1;
        last = -1;
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < NCORES; k++) set_core(k, 2'b01, DW'(k * 10));
        tick();
        bus.out_en_bus = '0;
        checks++;
        if (bus.core_busy !== '1) begin failures++; $display("FAIL all_busy got %0h want all ones", bus.core_busy); end
        for (int c = 1; c <= 120 && got.size() < NCORES; c++) begin
            tick();
            if (bus.out_valid) begin
                if (first < 0) first = c;
                last = c;
                got.push_back(int'(bus.out_data));
`ifdef COLLECTOR_TAG_EN
                ids.push_back(int'(bus.out_core_id));
`endif
            end
        end
        checks++;
        if (got.size() != NCORES) begin failures++; $display("FAIL all_count got %0d want %0d", got.size(), NCORES); end
        for (int i = 0; i < NCORES; i++) begin
            checks++;
            if (i >= got.size() || got[i] != i * 10) begin failures++; $display("FAIL all_data[%0d] got %0d want %0d", i, i < got.size() ? got[i] : -1, i * 10); end
        end
        checks++;
        if (first != 1 || last != NCORES) begin failures++; $display("FAIL all_timing got %0d..%0d want 1..%0d", first, last, NCORES); end
        checks++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 16'd0) begin failures++; $display("FAIL all_nodrop got %b/%0d want 0/0", bus.overflow, bus.drop_count); end
`ifdef COLLECTOR_TAG_EN
        for (int i = 0; i < NCORES; i++) begin
            checks++;
            if (i >= ids.size() || ids[i] != i) begin failures++; $display("FAIL all_id[%0d] got %0d want %0d", i, i < ids.size() ? ids[i] : -1, i); end
        end
`endif
    endtask

    task automatic test_back_to_back();
        int got[$];
        int cyc[$];
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            if (c < 10) set_core(3, 2'b01, DW'(100 + c));
            else bus.out_en_bus = '0;
            tick();
            if (bus.out_valid) begin
                got.push_back(int'(bus.out_data));
                cyc.push_back(c);
            end
        end
        bus.out_en_bus = '0;
        checks++;
        if (got.size() != 10) begin failures++; $display("FAIL b2b_count got %0d want 10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= got.size() || got[i] != 100 + i || cyc[i] != i + 1) begin failures++; $display("FAIL b2b[%0d] got %0d@%0d want %0d@%0d", i, i < got.size() ? got[i] : -1, i < cyc.size() ? cyc[i] : -1, 100 + i, i + 1); end
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.core_busy !== '0 || bus.drop_count !== 16'd0) begin failures++; $display("FAIL b2b_idle got valid=%b busy=%0h drops=%0d want 0/0/0", bus.out_valid, bus.core_busy, bus.drop_count); end
    endtask

    task automatic test_ignored_enables();
        logic [1:0] ens [3];
        ens = '{2'b10, 2'b11, 2'b00};
        bus.out_ready = 1'b1;
        for (int e = 0; e < 3; e++) begin
            set_core(7, ens[e], DW'(55));
            tick();
            checks++;
            if (bus.core_busy[7] !== 1'b0) begin failures++; $display("FAIL ignore_busy en=%b got %b want 0", ens[e], bus.core_busy[7]); end
            bus.out_en_bus = '0;
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL ignore_valid en=%b got %b want 0", ens[e], bus.out_valid); end
        end
    endtask

    task automatic test_overflow();
        int got[$];
        logic [NCORES-1:0] exp_busy;
        exp_busy = NCORES'(4'hF) << 16;
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            bus.out_en_bus = '0;
            set_core(k, 2'b01, DW'(1000 + k));
            tick();
        end
        bus.out_en_bus = '0;
        tick();
        checks++;
        if (bus.core_busy !== exp_busy) begin failures++; $display("FAIL ovf_held got %0h want %0h", bus.core_busy, exp_busy); end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(1000) || bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_full got valid=%b data=%0d ovf=%b want 1/1000/0", bus.out_valid, bus.out_data, bus.overflow); end
        set_core(17, 2'b01, DW'(9999));
        tick();
        bus.out_en_bus = '0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 16'd1) begin failures++; $display("FAIL ovf_drop got %b/%0d want 1/1", bus.overflow, bus.drop_count); end
        checks++;
        if (bus.core_busy !== exp_busy || bus.out_data !== DW'(1000)) begin failures++; $display("FAIL ovf_stable got busy=%0h data=%0d want %0h/1000", bus.core_busy, bus.out_data, exp_busy); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (bus.out_valid) got.push_back(int'(bus.out_data));
            tick();
        end
        checks++;
        if (got.size() != 20) begin failures++; $display("FAIL ovf_count got %0d want 20", got.size()); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= got.size() || got[i] != 1000 + i) begin failures++; $display("FAIL ovf_data[%0d] got %0d want %0d", i, i < got.size() ? got[i] : -1, 1000 + i); end
        end
        checks++;
        if (bus.core_busy !== '0 || bus.drop_count !== 16'd1) begin failures++; $display("FAIL ovf_end got busy=%0h drops=%0d want 0/1", bus.core_busy, bus.drop_count); end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        for (int k = 20; k < 25; k++) set_core(k, 2'b01, DW'(500 + k));
        tick();
        bus.out_en_bus = '0;
        repeat (6) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.drop_count !== 16'd1) begin failures++; $display("FAIL mid_queued got valid=%b drops=%0d want 1/1", bus.out_valid, bus.drop_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.drop_count !== 16'd0 || bus.overflow !== 1'b0 || bus.core_busy !== '0) begin failures++; $display("FAIL mid_reset got valid=%b drops=%0d ovf=%b busy=%0h want 0/0/0/0", bus.out_valid, bus.drop_count, bus.overflow, bus.core_busy); end
        bus.out_ready = 1'b1;
        set_core(47, 2'b01, DW'(777));
        set_core(3, 2'b01, DW'(333));
        tick();
        bus.out_en_bus = '0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_n1 got %b want 0", bus.out_valid); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(333)) begin failures++; $display("FAIL mid_first got valid=%b data=%0d want 1/333", bus.out_valid, bus.out_data); end
`ifdef COLLECTOR_TAG_EN
        checks++;
        if (bus.out_core_id !== IDW'(3)) begin failures++; $display("FAIL mid_first_id got %0d want 3", bus.out_core_id); end
`endif
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(777)) begin failures++; $display("FAIL mid_second got valid=%b data=%0d want 1/777", bus.out_valid, bus.out_data); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_saturation();
        logic [NCORES-1:0] exp_busy;
        exp_busy = ~(NCORES'(16'hFFFF));
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < NCORES; k++) set_core(k, 2'b01, DW'(k));
        tick();
        bus.out_en_bus = '0;
        repeat (18) tick();
        checks++;
        if (bus.core_busy !== exp_busy || bus.drop_count !== 16'd0) begin failures++; $display("FAIL sat_fill got busy=%0h drops=%0d want %0h/0", bus.core_busy, bus.drop_count, exp_busy); end
        for (int k = 0; k < NCORES; k++) set_core(k, 2'b01, DW'(k));
        tick();
        checks++;
        if (bus.drop_count !== 16'd32 || bus.overflow !== 1'b1 || bus.core_busy !== '1) begin failures++; $display("FAIL sat_multi got drops=%0d ovf=%b busy=%0h want 32/1/all", bus.drop_count, bus.overflow, bus.core_busy); end
        repeat (1364) tick();
        checks++;
        if (bus.drop_count !== 16'd65504) begin failures++; $display("FAIL sat_below got %0d want 65504", bus.drop_count); end
        tick();
        checks++;
        if (bus.drop_count !== 16'hFFFF) begin failures++; $display("FAIL sat_clip got %0d want 65535", bus.drop_count); end
        tick();
        checks++;
        if (bus.drop_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got %0d want 65535", bus.drop_count); end
        bus.out_en_bus = '0;
        do_reset();
    endtask

    initial begin
        bus.out_en_bus = '0;
        bus.io_out_bus = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_strobe();
        test_all_cores();
        test_back_to_back();
        test_ignored_enables();
        test_overflow();
        test_reset_midstream();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
